// File: rtl/elevator_pkg.sv
// Shared types for the elevator simulation: central FSM states, settings, keys.
// Pure declarations and combinational helpers, no latency.
// No flow control; consumers sample these encodings directly.
package elevator_pkg;

    typedef enum logic [1:0] {
        START  = 2'd0,
        SIM    = 2'd1,
        PAUSE  = 2'd2,
        ENDING = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PEOPLE         = 2'd0,
        ALGORITHM      = 2'd1,
        SIMSPEED       = 2'd2,
        SETTINGINVALID = 2'd3
    } setting_e;

    // Keys 0-9 are digits and carry no named literal.
    typedef enum logic [3:0] {
        STOP   = 4'hA,
        RESUME = 4'hB,
        UP     = 4'hC,
        DOWN   = 4'hD,
        ESCAPE = 4'hE,
        ENTER  = 4'hF
    } button_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        COMMIT = 2'd2,
        LOCKED = 2'd3
    } ctrl_state_e;

    // Cycle forward through the three real settings; an invalid code recovers to PEOPLE.
    function automatic setting_e setting_next(input setting_e s);
        case (s)
            PEOPLE:    return ALGORITHM;
            ALGORITHM: return SIMSPEED;
            default:   return PEOPLE;
        endcase
    endfunction

    // Cycle backward through the three real settings; an invalid code recovers to PEOPLE.
    function automatic setting_e setting_prev(input setting_e s);
        case (s)
            PEOPLE:    return SIMSPEED;
            ALGORITHM: return PEOPLE;
            SIMSPEED:  return ALGORITHM;
            default:   return PEOPLE;
        endcase
    endfunction

endpackage

// File: rtl/press_edge.sv
// Turns a held key level into a single-cycle press event.
// evt is combinational from pressed and the registered copy, asserted in the cycle the key goes down.
// No backpressure: one evt per rising edge of pressed regardless of hold time.
module press_edge (
    input  logic clk,
    input  logic rst,
    input  logic pressed,
    output logic evt
);

    logic pressed_q;

    // Remember last cycle's key level.
    always_ff @(posedge clk) begin
        if (rst) pressed_q <= 1'b0;
        else     pressed_q <= pressed;
    end

    assign evt = pressed & ~pressed_q;

endmodule

// File: rtl/sim_config_ctrl.sv
// Keypad configuration controller: select a setting, type a value, range-check and store on ENTER.
// Digit updates entry on the evt edge; a commit result appears one edge after the ENTER evt.
// No backpressure; key events are ignored whenever the simulation has left START.
module sim_config_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned MAX_PEOPLE = 40,
    parameter int unsigned MAX_ALGO   = 2,
    parameter int unsigned MAX_SPEED  = 7,
    parameter int unsigned DEF_PEOPLE = 10,
    parameter int unsigned DEF_ALGO   = 0,
    parameter int unsigned DEF_SPEED  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] buttonBus,
    input  logic       pressed,
    input  logic [1:0] simState,
    output logic [1:0] setting,
    output logic [5:0] people,
    output logic [1:0] algorithm,
    output logic [2:0] simSpeed,
    output logic [5:0] entry,
    output logic       editing,
    output logic       cfgDone,
    output logic       cfgError
);

    localparam logic [5:0] PEOPLE_MAX = 6'(MAX_PEOPLE);
    localparam logic [5:0] ALGO_MAX   = 6'(MAX_ALGO);
    localparam logic [5:0] SPEED_MAX  = 6'(MAX_SPEED);

    logic        evt;
    logic        lock;
    logic        is_digit;
    button_e     key;
    logic [9:0]  next_val;

    ctrl_state_e state_q, state_nx;
    setting_e    setting_q, setting_nx;
    logic [5:0]  people_q, people_nx;
    logic [1:0]  algo_q, algo_nx;
    logic [2:0]  speed_q, speed_nx;
    logic [5:0]  entry_q, entry_nx;
    logic        done_nx, error_nx;

    press_edge u_press_edge (
        .clk     (clk),
        .rst     (rst),
        .pressed (pressed),
        .evt     (evt)
    );

    assign lock     = (state_e'(simState) != START);
    assign is_digit = (buttonBus <= 4'd9);
    assign key      = button_e'(buttonBus);
    // Worst case 63*10+9 = 639 still fits in 10 bits, so the overflow test is exact.
    assign next_val = ({4'd0, entry_q} * 10'd10) + {6'd0, buttonBus};

    // Next-state and next-output logic; lock overrides every key and any pending commit.
    always_comb begin
        state_nx   = state_q;
        setting_nx = setting_q;
        people_nx  = people_q;
        algo_nx    = algo_q;
        speed_nx   = speed_q;
        entry_nx   = entry_q;
        done_nx    = 1'b0;
        error_nx   = 1'b0;

        if (lock) begin
            state_nx = LOCKED;
            entry_nx = '0;
        end else begin
            case (state_q)
                LOCKED: begin
                    state_nx   = IDLE;
                    setting_nx = PEOPLE;
                end
                IDLE: begin
                    if (evt) begin
                        if (is_digit) begin
                            entry_nx = {2'd0, buttonBus};
                            state_nx = ENTRY;
                        end else if (key == UP) begin
                            setting_nx = setting_next(setting_q);
                        end else if (key == DOWN) begin
                            setting_nx = setting_prev(setting_q);
                        end
                    end
                end
                ENTRY: begin
                    if (evt) begin
                        if (is_digit) begin
                            if (next_val <= 10'd63) entry_nx = next_val[5:0];
                        end else if (key == ESCAPE) begin
                            entry_nx = '0;
                            state_nx = IDLE;
                        end else if (key == ENTER) begin
                            state_nx = COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    state_nx = IDLE;
                    entry_nx = '0;
                    error_nx = 1'b1;
                    case (setting_q)
                        PEOPLE: begin
                            if (entry_q != 6'd0 && entry_q <= PEOPLE_MAX) begin
                                people_nx = entry_q;
                                done_nx   = 1'b1;
                                error_nx  = 1'b0;
                            end
                        end
                        ALGORITHM: begin
                            if (entry_q <= ALGO_MAX) begin
                                algo_nx  = entry_q[1:0];
                                done_nx  = 1'b1;
                                error_nx = 1'b0;
                            end
                        end
                        SIMSPEED: begin
                            if (entry_q != 6'd0 && entry_q <= SPEED_MAX) begin
                                speed_nx = entry_q[2:0];
                                done_nx  = 1'b1;
                                error_nx = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State and registered outputs; reset lands in LOCKED if the sim is already running.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= lock ? LOCKED : IDLE;
            setting_q <= PEOPLE;
            people_q  <= 6'(DEF_PEOPLE);
            algo_q    <= 2'(DEF_ALGO);
            speed_q   <= 3'(DEF_SPEED);
            entry_q   <= '0;
            editing   <= 1'b0;
            cfgDone   <= 1'b0;
            cfgError  <= 1'b0;
        end else begin
            state_q   <= state_nx;
            setting_q <= setting_nx;
            people_q  <= people_nx;
            algo_q    <= algo_nx;
            speed_q   <= speed_nx;
            entry_q   <= entry_nx;
            editing   <= (state_nx == ENTRY);
            cfgDone   <= done_nx;
            cfgError  <= error_nx;
        end
    end

    assign setting   = setting_q;
    assign people    = people_q;
    assign algorithm = algo_q;
    assign simSpeed  = speed_q;
    assign entry     = entry_q;

endmodule

// File: tb/tb_sim_config_ctrl.sv
// Directed bench for sim_config_ctrl with a scoreboard of expected commit results.
// Inputs change 1ns after the rising edge; the commit monitor samples on the falling edge.
// Every cfgDone/cfgError pulse must match the next queued expectation.
module tb_sim_config_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] buttonBus;
    logic       pressed;
    logic [1:0] simState;
    logic [1:0] setting;
    logic [5:0] people;
    logic [1:0] algorithm;
    logic [2:0] simSpeed;
    logic [5:0] entry;
    logic       editing;
    logic       cfgDone;
    logic       cfgError;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic       done;
        logic       err;
        logic [5:0] people;
        logic [1:0] algo;
        logic [2:0] speed;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [3:0] K_UP     = 4'hC;
    localparam logic [3:0] K_DOWN   = 4'hD;
    localparam logic [3:0] K_ESCAPE = 4'hE;
    localparam logic [3:0] K_ENTER  = 4'hF;

    sim_config_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .buttonBus (buttonBus),
        .pressed   (pressed),
        .simState  (simState),
        .setting   (setting),
        .people    (people),
        .algorithm (algorithm),
        .simSpeed  (simSpeed),
        .entry     (entry),
        .editing   (editing),
        .cfgDone   (cfgDone),
        .cfgError  (cfgError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One key tap: held for one edge (the evt edge), released for the next.
    task automatic press(input logic [3:0] k);
        buttonBus = k;
        pressed   = 1'b1;
        tick();
        pressed   = 1'b0;
        tick();
    endtask

    task automatic push_exp(input logic d, input logic e, input logic [5:0] p,
                            input logic [1:0] a, input logic [2:0] s);
        exp_t x;
        x.done = d; x.err = e; x.people = p; x.algo = a; x.speed = s;
        exp_q.push_back(x);
    endtask

    // Scoreboard: every commit pulse pops and checks one expectation.
    always @(negedge clk) begin
        if (!rst && (cfgDone || cfgError)) begin
            chk("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                chk("sb_done",   32'(cfgDone),   32'(x.done));
                chk("sb_error",  32'(cfgError),  32'(x.err));
                chk("sb_people", 32'(people),    32'(x.people));
                chk("sb_algo",   32'(algorithm), 32'(x.algo));
                chk("sb_speed",  32'(simSpeed),  32'(x.speed));
            end
        end
    end

    initial begin
        rst = 1'b1; pressed = 1'b0; buttonBus = 4'd0; simState = 2'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_people",  32'(people),    32'd10);
        chk("rst_algo",    32'(algorithm), 32'd0);
        chk("rst_speed",   32'(simSpeed),  32'd1);
        chk("rst_setting", 32'(setting),   32'd0);
        chk("rst_entry",   32'(entry),     32'd0);
        chk("rst_editing", 32'(editing),   32'd0);
        chk("rst_done",    32'(cfgDone),   32'd0);
        chk("rst_error",   32'(cfgError),  32'd0);

        // 2,5,ENTER with PEOPLE selected -> people=25
        buttonBus = 4'd2; pressed = 1'b1;
        tick();
        chk("digit_same_edge", 32'(entry), 32'd2);
        pressed = 1'b0;
        tick();
        chk("editing_on", 32'(editing), 32'd1);
        press(4'd5);
        chk("entry_25", 32'(entry), 32'd25);
        push_exp(1'b1, 1'b0, 6'd25, 2'd0, 3'd1);
        buttonBus = K_ENTER; pressed = 1'b1;
        tick();
        chk("commit_not_yet", 32'(people), 32'd10);
        pressed = 1'b0;
        tick();
        chk("people_25",  32'(people),  32'd25);
        chk("done_pulse", 32'(cfgDone), 32'd1);
        chk("entry_clr",  32'(entry),   32'd0);

        // UP,UP, 9, ENTER -> SIMSPEED rejects 9
        press(K_UP);
        press(K_UP);
        chk("setting_2", 32'(setting), 32'd2);
        press(4'd9);
        push_exp(1'b0, 1'b1, 6'd25, 2'd0, 3'd1);
        press(K_ENTER);
        chk("speed_kept", 32'(simSpeed), 32'd1);
        chk("error_pulse", 32'(cfgError), 32'd1);
        press(K_DOWN);
        chk("down_1", 32'(setting), 32'd1);
        press(K_DOWN);
        chk("down_0", 32'(setting), 32'd0);
        press(K_DOWN);
        chk("down_wrap", 32'(setting), 32'd2);

        // 6,4 -> 64 overflows, digit dropped; ESCAPE clears
        press(4'd6);
        press(4'd4);
        chk("overflow_hold", 32'(entry), 32'd6);
        press(K_ESCAPE);
        chk("esc_entry",   32'(entry),   32'd0);
        chk("esc_editing", 32'(editing), 32'd0);
        chk("esc_people",  32'(people),  32'd25);

        // Held key produces one event only
        buttonBus = 4'd3; pressed = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        pressed = 1'b0;
        tick();
        chk("held_once", 32'(entry), 32'd3);

        // Lock out, ENTER ignored, unlock returns to PEOPLE
        simState = 2'd1;
        tick();
        chk("lock_entry",   32'(entry),   32'd0);
        chk("lock_editing", 32'(editing), 32'd0);
        press(K_ENTER);
        press(4'd7);
        chk("lock_ignore", 32'(entry), 32'd0);
        simState = 2'd0;
        tick();
        chk("unlock_setting", 32'(setting), 32'd0);
        chk("unlock_people",  32'(people),  32'd25);

        // ALGORITHM accepts its maximum, 2
        press(K_UP);
        press(4'd2);
        push_exp(1'b1, 1'b0, 6'd25, 2'd2, 3'd1);
        press(K_ENTER);
        chk("algo_2", 32'(algorithm), 32'd2);

        // ENTER in the same cycle as leaving START: lock wins, no commit
        press(4'd1);
        buttonBus = K_ENTER; pressed = 1'b1; simState = 2'd1;
        tick();
        pressed = 1'b0;
        tick(); tick();
        chk("race_algo",  32'(algorithm), 32'd2);
        chk("race_entry", 32'(entry),     32'd0);
        simState = 2'd0;
        tick();
        chk("race_setting", 32'(setting), 32'd0);

        // Reset in the middle of an entry restores all defaults
        press(4'd4);
        chk("pre_rst_edit", 32'(editing), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_entry",   32'(entry),     32'd0);
        chk("mid_rst_editing", 32'(editing),   32'd0);
        chk("mid_rst_people",  32'(people),    32'd10);
        chk("mid_rst_algo",    32'(algorithm), 32'd0);
        chk("mid_rst_speed",   32'(simSpeed),  32'd1);
        tick(); tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
